fetch_controller: RTL and testbench
===================================

// Module: fetch_controller
// PURPOSE
//  Sequences the instruction-fetch datapath: owns the PC, issues word reads to
//  the instruction memory over a req/ready handshake, and loads the IF/ID
//  register (if_valid/if_pc/if_instr). Sits between the hazard/branch logic
//  (freeze, br_taken) and the instruction RAM. Handles stalls, branch
//  redirects, and memory wait states, including branches that arrive mid-read.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
//  PC_STEP   4              byte increment per sequential fetch
// PORTS
//  clk        in   1   system clock, all state on posedge
//  rst        in   1   asynchronous reset, active-high
//  freeze     in   1   hazard stall from ID; hold IF/ID register contents
//  br_taken   in   1   one-cycle pulse from EXE: redirect fetch, flush IF/ID
//  br_addr    in   32  branch target byte address; bits [1:0] forced to 0
//  mem_req    out  1   read request to instruction memory
//  mem_addr   out  32  byte address of read; memory indexes word pc[11:2]
//  mem_ready  in   1   read complete this cycle; mem_rdata valid
//  mem_rdata  in   32  instruction word
//  if_valid   out  1   IF/ID register holds a real instruction
//  if_pc      out  32  fetch address + PC_STEP (next-sequential PC)
//  if_instr   out  32  fetched instruction; 0 when bubble
//  flush      out  1   registered one-cycle pulse, IF/ID cleared by branch
// BEHAVIOUR
//  Reset (async, immediate): pc=RESET_PC, state=FETCH, mem_req=0, mem_addr=0,
//   if_valid=0, if_pc=0, if_instr=0, flush=0, hold buffer cleared.
//  States: FETCH, HOLD, DROP. mem_req is registered; mem_addr = pc.
//  FETCH: mem_req=1 from first cycle after reset release. mem_addr stable
//   while mem_req=1 and mem_ready=0. Accept = mem_req & mem_ready at posedge.
//   - accept, freeze=0: if_valid<=1, if_instr<=mem_rdata, if_pc<=pc+PC_STEP,
//     pc<=pc+PC_STEP, stay FETCH. ready tied 1 -> one instruction/cycle.
//   - accept, freeze=1: store rdata/pc+PC_STEP in hold buffer, if_* unchanged,
//     mem_req<=0, -> HOLD.
//   - no accept: freeze=1 keeps if_*; freeze=0 sets if_valid<=0, if_instr<=0.
//  HOLD: mem_req=0, if_* held while freeze=1. freeze=0: load buffer into if_*
//   (if_valid<=1), pc<=pc+PC_STEP, -> FETCH (new request next cycle).
//  Branch (br_taken=1) has priority over freeze and accept in every state:
//   pc<={br_addr[31:2],2'b00}; if_valid<=0, if_instr<=0, if_pc<=0; flush<=1
//   for exactly one cycle; hold buffer discarded.
//   - FETCH with pending read (mem_req=1, mem_ready=0) -> DROP.
//   - FETCH with accept same cycle: data discarded, -> FETCH at target.
//   - HOLD -> FETCH at target.
//  DROP: mem_req stays 1 with old mem_addr (protocol: request may not be
//   withdrawn); on mem_ready data discarded, mem_addr<=new pc, -> FETCH.
//   br_taken again in DROP: retarget pc, stay DROP.
//  PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
//  if_valid=0 never coincides with nonzero if_instr.
// TESTING
//  1 Reset release, mem_ready=1, rdata=addr>>2 -> mem_addr 0,4,8,12 on
//    consecutive cycles; if_pc 4,8,12 with if_instr 0,1,2, if_valid=1.
//  2 mem_ready low 2 cycles on addr 8 -> mem_addr=8 for 3 cycles, if_valid=0
//    for 2 cycles, then if_instr=2, if_pc=12.
//  3 freeze=1 for 3 cycles starting at accept of addr 8 -> if_instr=1, if_pc=8
//    held; mem_req=0; cycle after freeze drops if_instr=2, if_pc=12, then
//    mem_addr=12.
//  4 br_taken, br_addr=32'h43, while read of 0x10 pending, ready 2 cycles
//    later -> flush=1 one cycle, if_valid=0, instr of 0x10 never on if_instr,
//    next mem_addr=32'h40, then if_pc=32'h44.
//  5 br_taken and freeze together in HOLD -> buffer discarded, if_valid=0,
//    next fetch at target; pc wrap: RESET_PC=32'hFFFF_FFFC -> mem_addr FFFF_FFFC
//    then 0.
//  6 rst asserted mid-DROP -> all outputs 0 same cycle; after release
//    mem_addr=RESET_PC, sequence of test 1 resumes.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, reads instruction words over a
// req/ready handshake and loads the IF/ID register, with stall, branch and wait-state handling.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        br_taken,
  input  logic [31:0] br_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        flush
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic            mem_req_q;
  logic [XLEN-1:0] mem_addr_q;
  logic            if_valid_q;
  logic [XLEN-1:0] if_pc_q;
  logic [XLEN-1:0] if_instr_q;
  logic            flush_q;
  logic [XLEN-1:0] hold_instr_q;
  logic [XLEN-1:0] hold_pc_q;

  logic [XLEN-1:0] pc_step_c;
  logic [XLEN-1:0] br_tgt_c;
  logic            accept_c;
  logic            unused_c;

  assign pc_step_c = pc_q + XLEN'(PC_STEP);
  assign br_tgt_c  = {br_addr[31:2], 2'b00};
  assign accept_c  = mem_req_q & mem_ready;
  assign unused_c  = ^br_addr[1:0];

  // Branch beats freeze and accept; a read already on the bus must be drained in DROP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= {RESET_PC[31:2], 2'b00};
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= '0;
      flush_q      <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      flush_q <= br_taken;
      if (br_taken) begin
        pc_q         <= br_tgt_c;
        if_valid_q   <= 1'b0;
        if_pc_q      <= '0;
        if_instr_q   <= '0;
        hold_instr_q <= '0;
        hold_pc_q    <= '0;
        if (mem_req_q && !mem_ready) begin
          state_q <= S_DROP;
        end else begin
          state_q    <= S_FETCH;
          mem_req_q  <= 1'b1;
          mem_addr_q <= br_tgt_c;
        end
      end else begin
        case (state_q)
          S_FETCH: begin
            if (accept_c) begin
              if (!freeze) begin
                if_valid_q <= 1'b1;
                if_instr_q <= mem_rdata;
                if_pc_q    <= pc_step_c;
                pc_q       <= pc_step_c;
                mem_addr_q <= pc_step_c;
              end else begin
                hold_instr_q <= mem_rdata;
                hold_pc_q    <= pc_step_c;
                mem_req_q    <= 1'b0;
                state_q      <= S_HOLD;
              end
            end else begin
              if (!mem_req_q) begin
                mem_req_q  <= 1'b1;
                mem_addr_q <= pc_q;
              end
              if (!freeze) begin
                if_valid_q <= 1'b0;
                if_instr_q <= '0;
              end
            end
          end
          S_HOLD: begin
            if (!freeze) begin
              if_valid_q   <= 1'b1;
              if_instr_q   <= hold_instr_q;
              if_pc_q      <= hold_pc_q;
              pc_q         <= pc_step_c;
              mem_req_q    <= 1'b1;
              mem_addr_q   <= pc_step_c;
              hold_instr_q <= '0;
              hold_pc_q    <= '0;
              state_q      <= S_FETCH;
            end
          end
          S_DROP: begin
            // Stale read completes; its data never reaches IF/ID.
            if (mem_ready) begin
              mem_addr_q <= pc_q;
              state_q    <= S_FETCH;
            end
          end
          default: begin
            state_q   <= S_FETCH;
            mem_req_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;
  assign flush    = flush_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller; memory returns addr>>2 as the instruction.
module tb_fetch_controller;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        br_taken;
  logic [31:0] br_addr;
  logic        mem_ready;
  logic        mem_req,   w_mem_req;
  logic [31:0] mem_addr,  w_mem_addr;
  logic [31:0] mem_rdata, w_mem_rdata;
  logic        if_valid,  w_if_valid;
  logic [31:0] if_pc,     w_if_pc;
  logic [31:0] if_instr,  w_if_instr;
  logic        flush,     w_flush;

  int total;
  int bad;

  assign mem_rdata   = mem_addr >> 2;
  assign w_mem_rdata = w_mem_addr >> 2;

  fetch_controller dut (
    .clk(clk), .rst(rst), .freeze(freeze), .br_taken(br_taken), .br_addr(br_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .flush(flush)
  );

  fetch_controller #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_w (
    .clk(clk), .rst(rst), .freeze(freeze), .br_taken(br_taken), .br_addr(br_addr),
    .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_ready(mem_ready), .mem_rdata(w_mem_rdata),
    .if_valid(w_if_valid), .if_pc(w_if_pc), .if_instr(w_if_instr), .flush(w_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; freeze = 1'b0; br_taken = 1'b0; br_addr = '0; mem_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; freeze = 1'b0; br_taken = 1'b0; br_addr = '0; mem_ready = 1'b1;
    step();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", mem_req); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
    total++; if ({if_valid, if_pc, if_instr, flush} !== 66'h0) begin bad++;
      $display("FAIL rst_if got v=%b pc=%h i=%h f=%b exp all 0", if_valid, if_pc, if_instr, flush); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    step();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin bad++;
      $display("FAIL t1_first got req=%b addr=%h exp req=1 addr=0", mem_req, mem_addr); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL t1_first_v got=%b exp=0", if_valid); end
    for (int k = 1; k <= 3; k++) begin
      step();
      total++; if (mem_addr !== 32'(4 * k)) begin bad++;
        $display("FAIL t1_addr k=%0d got=%h exp=%h", k, mem_addr, 32'(4 * k)); end
      total++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * k) || if_instr !== 32'(k - 1)) begin bad++;
        $display("FAIL t1_if k=%0d got v=%b pc=%h i=%h exp v=1 pc=%h i=%h",
                 k, if_valid, if_pc, if_instr, 32'(4 * k), 32'(k - 1)); end
    end
  endtask

  task automatic test_wait_state();
    do_reset();
    step(); step(); step();
    total++; if (mem_addr !== 32'h8 || if_instr !== 32'h1) begin bad++;
      $display("FAIL t2_pre got addr=%h i=%h exp addr=8 i=1", mem_addr, if_instr); end
    mem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin bad++;
        $display("FAIL t2_hold_addr k=%0d got req=%b addr=%h exp req=1 addr=8", k, mem_req, mem_addr); end
      total++; if (if_valid !== 1'b0 || if_instr !== 32'h0) begin bad++;
        $display("FAIL t2_bubble k=%0d got v=%b i=%h exp v=0 i=0", k, if_valid, if_instr); end
    end
    mem_ready = 1'b1;
    step();
    total++; if (if_valid !== 1'b1 || if_instr !== 32'h2 || if_pc !== 32'hC || mem_addr !== 32'hC) begin bad++;
      $display("FAIL t2_resume got v=%b i=%h pc=%h addr=%h exp v=1 i=2 pc=c addr=c",
               if_valid, if_instr, if_pc, mem_addr); end
  endtask

  task automatic test_freeze();
    do_reset();
    step(); step(); step();
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (if_valid !== 1'b1 || if_instr !== 32'h1 || if_pc !== 32'h8) begin bad++;
        $display("FAIL t3_held k=%0d got v=%b i=%h pc=%h exp v=1 i=1 pc=8", k, if_valid, if_instr, if_pc); end
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL t3_req k=%0d got=%b exp=0", k, mem_req); end
    end
    freeze = 1'b0;
    step();
    total++; if (if_valid !== 1'b1 || if_instr !== 32'h2 || if_pc !== 32'hC) begin bad++;
      $display("FAIL t3_release got v=%b i=%h pc=%h exp v=1 i=2 pc=c", if_valid, if_instr, if_pc); end
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'hC) begin bad++;
      $display("FAIL t3_refetch got req=%b addr=%h exp req=1 addr=c", mem_req, mem_addr); end
    step();
    total++; if (if_instr !== 32'h3 || if_pc !== 32'h10) begin bad++;
      $display("FAIL t3_next got i=%h pc=%h exp i=3 pc=10", if_instr, if_pc); end
  endtask

  task automatic test_branch_pending();
    do_reset();
    for (int k = 0; k < 5; k++) step();
    total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL t4_pre got=%h exp=10", mem_addr); end
    mem_ready = 1'b0; br_taken = 1'b1; br_addr = 32'h43;
    step();
    br_taken = 1'b0;
    total++; if (flush !== 1'b1 || if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0) begin bad++;
      $display("FAIL t4_flush got f=%b v=%b i=%h pc=%h exp f=1 v=0 i=0 pc=0", flush, if_valid, if_instr, if_pc); end
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin bad++;
      $display("FAIL t4_keep got req=%b addr=%h exp req=1 addr=10", mem_req, mem_addr); end
    step();
    total++; if (flush !== 1'b0 || if_valid !== 1'b0 || mem_addr !== 32'h10) begin bad++;
      $display("FAIL t4_drop got f=%b v=%b addr=%h exp f=0 v=0 addr=10", flush, if_valid, mem_addr); end
    mem_ready = 1'b1;
    step();
    total++; if (mem_addr !== 32'h40 || if_valid !== 1'b0 || if_instr !== 32'h0) begin bad++;
      $display("FAIL t4_retarget got addr=%h v=%b i=%h exp addr=40 v=0 i=0", mem_addr, if_valid, if_instr); end
    step();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h44 || if_instr !== 32'h10) begin bad++;
      $display("FAIL t4_target got v=%b pc=%h i=%h exp v=1 pc=44 i=10", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_branch_hold_and_wrap();
    do_reset();
    step();
    total++; if (w_mem_addr !== 32'hFFFF_FFFC) begin bad++;
      $display("FAIL t5_wrap_first got=%h exp=fffffffc", w_mem_addr); end
    step();
    total++; if (w_mem_addr !== 32'h0 || w_if_pc !== 32'h0 || w_if_instr !== 32'h3FFF_FFFF) begin bad++;
      $display("FAIL t5_wrap got addr=%h pc=%h i=%h exp addr=0 pc=0 i=3fffffff", w_mem_addr, w_if_pc, w_if_instr); end
    freeze = 1'b1;
    step();
    total++; if (mem_req !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h4) begin bad++;
      $display("FAIL t5_hold got req=%b i=%h pc=%h exp req=0 i=0 pc=4", mem_req, if_instr, if_pc); end
    br_taken = 1'b1; br_addr = 32'h100;
    step();
    br_taken = 1'b0; freeze = 1'b0;
    total++; if (flush !== 1'b1 || if_valid !== 1'b0 || if_instr !== 32'h0) begin bad++;
      $display("FAIL t5_br got f=%b v=%b i=%h exp f=1 v=0 i=0", flush, if_valid, if_instr); end
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin bad++;
      $display("FAIL t5_br_addr got req=%b addr=%h exp req=1 addr=100", mem_req, mem_addr); end
    step();
    total++; if (if_valid !== 1'b1 || if_instr !== 32'h40 || if_pc !== 32'h104 || flush !== 1'b0) begin bad++;
      $display("FAIL t5_target got v=%b i=%h pc=%h f=%b exp v=1 i=40 pc=104 f=0", if_valid, if_instr, if_pc, flush); end
  endtask

  task automatic test_reset_in_drop();
    do_reset();
    step(); step();
    mem_ready = 1'b0; br_taken = 1'b1; br_addr = 32'h80;
    step();
    br_taken = 1'b0;
    total++; if (flush !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h4) begin bad++;
      $display("FAIL t6_drop got f=%b req=%b addr=%h exp f=1 req=1 addr=4", flush, mem_req, mem_addr); end
    #2;
    rst = 1'b1;
    #1;
    total++; if ({mem_req, mem_addr, if_valid, if_pc, if_instr, flush} !== 99'h0) begin bad++;
      $display("FAIL t6_async got req=%b addr=%h v=%b pc=%h i=%h f=%b exp all 0",
               mem_req, mem_addr, if_valid, if_pc, if_instr, flush); end
    mem_ready = 1'b1;
    step();
    rst = 1'b0;
    step();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin bad++;
      $display("FAIL t6_restart got req=%b addr=%h exp req=1 addr=0", mem_req, mem_addr); end
    for (int k = 1; k <= 3; k++) begin
      step();
      total++; if (mem_addr !== 32'(4 * k) || if_pc !== 32'(4 * k) || if_instr !== 32'(k - 1)) begin bad++;
        $display("FAIL t6_seq k=%0d got addr=%h pc=%h i=%h exp addr=%h pc=%h i=%h",
                 k, mem_addr, if_pc, if_instr, 32'(4 * k), 32'(4 * k), 32'(k - 1)); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_stream();
    test_wait_state();
    test_freeze();
    test_branch_pending();
    test_branch_hold_and_wrap();
    test_reset_in_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
